if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Fetch-stage producer for the IF/ID pipeline register. It owns the PC, issues one
//  instruction-memory request at a time and presents instr_if32/pc_plus4_if32/valid_if.
//  Decode back-pressure (stall_i) and branch/jump redirects (redirect_i) from later stages
//  control it. Memory latency is variable; at most one request is outstanding.
// PARAMETERS
//  WIDTH     32  data/address width in bits (>= 3)
//  RESET_PC  0   PC loaded on reset
// PORTS
//  clk_i          in   1      clock, all state updates on posedge
//  reset_i        in   1      synchronous reset, active-high
//  stall_i        in   1      decode cannot accept; hold presented instruction
//  redirect_i     in   1      flush and restart fetch at redirect_pc_i
//  redirect_pc_i  in   WIDTH  redirect target
//  imem_req_o     out  1      request valid
//  imem_addr_o    out  WIDTH  request address, word aligned
//  imem_gnt_i     in   1      request accepted this cycle
//  imem_rvalid_i  in   1      response valid, one per accepted request
//  imem_rdata_i   in   WIDTH  response instruction
//  instr_if32     out  WIDTH  fetched instruction to IF/ID
//  pc_plus4_if32  out  WIDTH  address of that instruction + 4
//  valid_if       out  1      instr_if32/pc_plus4_if32 hold a live instruction
// BEHAVIOUR
//  - Reset (sync): pc=RESET_PC, state=FETCH, kill=0, skid empty; instr_if32=0,
//    pc_plus4_if32=0, valid_if=0. Applies mid-transaction; in-flight data is abandoned.
//  - imem_addr_o = {pc[WIDTH-1:2],2'b00}; imem_req_o=1 only in FETCH. Registered outputs.
//  - "Consume": a cycle with valid_if=1 and stall_i=0. Consume clears the output slot
//    unless it is refilled in the same cycle.
//  - FSM:
//    FETCH: req=1. gnt -> WAIT.
//    WAIT:  req=0. rvalid with kill=1 -> drop data, kill<=0, -> FETCH.
//           rvalid with slot free or consumed this cycle -> load outputs
//           (instr=rdata, pc_plus4=pc+4, valid=1), pc<=pc+4, -> FETCH.
//           rvalid with slot busy and stalled -> rdata/pc+4 into skid, pc<=pc+4, -> HOLD.
//    HOLD:  req=0. On consume -> skid moves to outputs, skid empty, -> FETCH.
//  - imem_rvalid_i is ignored outside WAIT.
//  - Latency: gnt in cycle n, rvalid in cycle m>=n+1 -> valid_if=1 in cycle m+1.
//    Back-to-back with zero-wait memory: one instruction every 2 cycles.
//  - Redirect (priority over stall and all other events), effective next cycle:
//    valid_if<=0, skid emptied, pc<=redirect_pc_i.
//    FETCH: stay FETCH. A gnt in the redirect cycle goes to WAIT with kill<=1.
//    WAIT: kill<=1, stay WAIT. A same-cycle rvalid is dropped and kill stays 0.
//    HOLD -> FETCH.
//  - pc+4 wraps modulo 2^WIDTH (0xFFFFFFFC -> 0x00000000 for WIDTH=32). No error flag.
//  - Outputs are stable while valid_if=1 and stall_i=1. Redirect is the only exception.
// TESTING
//  1 Reset then zero-wait memory (gnt same cycle, rvalid next cycle), RESET_PC=0 ->
//    addrs 0,4,8; valid_if pulses deliver pc_plus4 4,8,12 every 2nd cycle.
//  2 stall_i=1 for 5 cycles while valid_if=1 and a response arrives ->
//    outputs unchanged, state HOLD, no req. Release -> skid instr presented next cycle.
//  3 redirect_i with redirect_pc_i=0x100 while in WAIT, rvalid 2 cycles later ->
//    response dropped, valid_if=0, next req addr 0x100.
//  4 redirect_i in same cycle as gnt -> kill set; that response is discarded.
//    The following fetch uses the redirect target.
//  5 reset_i asserted mid-WAIT, rvalid arrives after reset -> ignored; req at RESET_PC.
//  6 pc=0xFFFFFFFC fetch -> pc_plus4_if32=0, next addr 0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//    Fetch-stage producer for the IF/ID pipeline register. Owns the PC. Keeps at
//    most one instruction-memory request outstanding. Presents the fetched
//    instruction together with its address + 4. A one-entry skid buffer absorbs a
//    response that arrives while decode is stalled on the previous instruction.
//
// Ports
//    clk_i, reset_i              clock, synchronous active-high reset
//    stall_i                     decode cannot accept; hold presented instruction
//    redirect_i, redirect_pc_i   flush and restart fetch at redirect_pc_i
//    imem_req_o, imem_addr_o     request valid / word-aligned address
//    imem_gnt_i                  request accepted this cycle
//    imem_rvalid_i, imem_rdata_i response valid / instruction data
//    instr_if32, pc_plus4_if32   fetched instruction and its address + 4
//    valid_if                    output slot holds a live instruction
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_FETCH | request driven at pc, waiting for grant
// S_WAIT  | request granted, waiting for response (kill = drop response)
// S_HOLD  | response parked in skid, output slot stalled; no request

module if_fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             stall_i,
   input  logic             redirect_i,
   input  logic [WIDTH-1:0] redirect_pc_i,
   output logic             imem_req_o,
   output logic [WIDTH-1:0] imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [WIDTH-1:0] imem_rdata_i,
   output logic [WIDTH-1:0] instr_if32,
   output logic [WIDTH-1:0] pc_plus4_if32,
   output logic             valid_if
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] pc, pc_n;
   logic             kill, kill_n;
   logic [WIDTH-1:0] skid_instr, skid_instr_n;
   logic [WIDTH-1:0] skid_pc4, skid_pc4_n;
   logic [WIDTH-1:0] instr_n, pc4_n;
   logic             valid_n;
   logic [WIDTH-1:0] pc_inc;
   logic             consume;

   assign pc_inc      = pc + WIDTH'(4);
   assign consume     = valid_if & ~stall_i;
   assign imem_req_o  = (state == S_FETCH);
   assign imem_addr_o = {pc[WIDTH-1:2], 2'b00};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state         <= S_FETCH;
         pc            <= RESET_PC;
         kill          <= 1'b0;
         skid_instr    <= '0;
         skid_pc4      <= '0;
         instr_if32    <= '0;
         pc_plus4_if32 <= '0;
         valid_if      <= 1'b0;
      end else begin
         state         <= state_n;
         pc            <= pc_n;
         kill          <= kill_n;
         skid_instr    <= skid_instr_n;
         skid_pc4      <= skid_pc4_n;
         instr_if32    <= instr_n;
         pc_plus4_if32 <= pc4_n;
         valid_if      <= valid_n;
      end
   end

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      kill_n       = kill;
      skid_instr_n = skid_instr;
      skid_pc4_n   = skid_pc4;
      instr_n      = instr_if32;
      pc4_n        = pc_plus4_if32;
      valid_n      = valid_if;

      if (redirect_i) begin
         valid_n = 1'b0;
         pc_n    = redirect_pc_i;
         case (state)
            S_FETCH: begin
               // A grant in the redirect cycle belongs to the old path.
               if (imem_gnt_i) begin
                  state_n = S_WAIT;
                  kill_n  = 1'b1;
               end
            end
            S_WAIT: begin
               // Response arriving alongside the redirect is dropped here and
               // nothing remains outstanding, so fetch can restart at once.
               if (imem_rvalid_i) begin
                  kill_n  = 1'b0;
                  state_n = S_FETCH;
               end else begin
                  kill_n = 1'b1;
               end
            end
            S_HOLD:  state_n = S_FETCH;
            default: state_n = S_FETCH;
         endcase
      end else begin
         if (consume) valid_n = 1'b0;
         case (state)
            S_FETCH: begin
               if (imem_gnt_i) state_n = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid_i) begin
                  if (kill) begin
                     kill_n  = 1'b0;
                     state_n = S_FETCH;
                  end else if (!valid_if || consume) begin
                     instr_n = imem_rdata_i;
                     pc4_n   = pc_inc;
                     valid_n = 1'b1;
                     pc_n    = pc_inc;
                     state_n = S_FETCH;
                  end else begin
                     skid_instr_n = imem_rdata_i;
                     skid_pc4_n   = pc_inc;
                     pc_n         = pc_inc;
                     state_n      = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (consume) begin
                  instr_n = skid_instr;
                  pc4_n   = skid_pc4;
                  valid_n = 1'b1;
                  state_n = S_FETCH;
               end
            end
            default: state_n = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit
//    Directed vector table for the fetch unit corner cases, followed by a
//    randomized run against a transaction-level reference model (outstanding
//    flag, kill flag, skid queue, output slot) and a single-outstanding memory.

module tb_if_fetch_unit;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] instr_if32;
   logic [31:0] pc_plus4_if32;
   logic        valid_if;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   if_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_if32    (instr_if32),
      .pc_plus4_if32 (pc_plus4_if32),
      .valid_if      (valid_if)
   );

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic        chk_data;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, input logic stall, input logic redir,
                      input logic [31:0] rpc, input logic gnt, input logic rv,
                      input logic [31:0] rdata, input logic e_req,
                      input logic [31:0] e_addr, input logic e_valid,
                      input logic chk_data, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4);
      vec_t v;
      v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc;
      v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.e_req = e_req;
      v.e_addr = e_addr; v.e_valid = e_valid; v.chk_data = chk_data;
      v.e_instr = e_instr; v.e_pc4 = e_pc4;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic stall, input logic redir,
                        input logic [31:0] rpc, input logic gnt,
                        input logic rv, input logic [31:0] rdata);
      reset_i       = rst;
      stall_i       = stall;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      imem_gnt_i    = gnt;
      imem_rvalid_i = rv;
      imem_rdata_i  = rdata;
   endtask

   // Reference model
   typedef struct packed {
      logic [31:0] i;
      logic [31:0] p;
   } ent_t;

   logic        m_busy, m_kill, m_valid;
   logic [31:0] m_pc, m_instr, m_pc4;
   ent_t        m_skid[$];

   function automatic logic m_req();
      return !m_busy && (m_skid.size() == 0);
   endfunction

   task automatic model_step(input logic r, input logic st, input logic rd,
                             input logic [31:0] rpc, input logic g,
                             input logic rv, input logic [31:0] rdat);
      logic req, cons, old_valid;
      ent_t e;
      if (r) begin
         m_pc = 32'h0; m_busy = 1'b0; m_kill = 1'b0; m_skid.delete();
         m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      end else if (rd) begin
         m_valid = 1'b0;
         if (m_skid.size() > 0) m_skid.delete();
         else if (m_busy) begin
            if (rv) begin m_busy = 1'b0; m_kill = 1'b0; end
            else m_kill = 1'b1;
         end else if (g) begin
            m_busy = 1'b1; m_kill = 1'b1;
         end
         m_pc = rpc;
      end else begin
         req       = m_req();
         old_valid = m_valid;
         cons      = m_valid && !st;
         if (cons) m_valid = 1'b0;
         if (req) begin
            if (g) m_busy = 1'b1;
         end else if (m_busy) begin
            if (rv) begin
               m_busy = 1'b0;
               if (m_kill) m_kill = 1'b0;
               else begin
                  if (!old_valid || cons) begin
                     m_valid = 1'b1; m_instr = rdat; m_pc4 = m_pc + 32'd4;
                  end else begin
                     e.i = rdat; e.p = m_pc + 32'd4;
                     m_skid.push_back(e);
                  end
                  m_pc = m_pc + 32'd4;
               end
            end
         end else if (cons) begin
            e = m_skid.pop_front();
            m_valid = 1'b1; m_instr = e.i; m_pc4 = e.p;
         end
      end
   endtask

   initial begin
      logic        rst, st, rd, g, rv, mem_pend;
      logic [31:0] rpc, rdat, mem_data;
      vec_t v;

      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk_i); @(posedge clk_i); #1;
      chk("reset_req",   -1, {31'h0, imem_req_o}, 32'h1);
      chk("reset_addr",  -1, imem_addr_o, 32'h0);
      chk("reset_valid", -1, {31'h0, valid_if}, 32'h0);
      chk("reset_instr", -1, instr_if32, 32'h0);
      chk("reset_pc4",   -1, pc_plus4_if32, 32'h0);

      // rst st rd rpc gnt rv rdata | req addr valid chk instr pc4
      add(0,0,0,32'h0,1,0,32'h0,          0,32'h0,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,0,1,32'hA000_0000,  1,32'h4,1,1,32'hA000_0000,32'h4);
      add(0,0,0,32'h0,1,0,32'h0,          0,32'h0,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,0,1,32'hA000_0001,  1,32'h8,1,1,32'hA000_0001,32'h8);
      add(0,0,0,32'h0,1,0,32'h0,          0,32'h0,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,0,1,32'hA000_0002,  1,32'hC,1,1,32'hA000_0002,32'hC);
      add(0,1,0,32'h0,1,0,32'h0,          0,32'h0,1,1,32'hA000_0002,32'hC);
      add(0,1,0,32'h0,0,1,32'hA000_0003,  0,32'h0,1,1,32'hA000_0002,32'hC);
      add(0,1,0,32'h0,0,0,32'h0,          0,32'h0,1,1,32'hA000_0002,32'hC);
      add(0,1,0,32'h0,0,0,32'h0,          0,32'h0,1,1,32'hA000_0002,32'hC);
      add(0,1,0,32'h0,0,0,32'h0,          0,32'h0,1,1,32'hA000_0002,32'hC);
      add(0,0,0,32'h0,0,0,32'h0,          1,32'h10,1,1,32'hA000_0003,32'h10);
      add(0,0,0,32'h0,1,0,32'h0,          0,32'h0,0,0,32'h0,32'h0);
      add(0,0,1,32'h100,0,0,32'h0,        0,32'h0,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,0,0,32'h0,          0,32'h0,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,0,1,32'hA000_0004,  1,32'h100,0,0,32'h0,32'h0);
      add(0,0,1,32'h200,1,0,32'h0,        0,32'h0,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,0,1,32'hA000_0005,  1,32'h200,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,1,0,32'h0,          0,32'h0,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,0,1,32'hA000_0006,  1,32'h204,1,1,32'hA000_0006,32'h204);
      add(0,0,1,32'hFFFF_FFFC,0,0,32'h0,  1,32'hFFFF_FFFC,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,1,0,32'h0,          0,32'h0,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,0,1,32'hA000_0007,  1,32'h0,1,1,32'hA000_0007,32'h0);
      add(0,0,0,32'h0,1,0,32'h0,          0,32'h0,0,0,32'h0,32'h0);
      add(1,0,0,32'h0,0,0,32'h0,          1,32'h0,0,1,32'h0,32'h0);
      add(0,0,0,32'h0,0,1,32'hA000_0008,  1,32'h0,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,1,0,32'h0,          0,32'h0,0,0,32'h0,32'h0);
      add(0,0,0,32'h0,0,1,32'hA000_0009,  1,32'h4,1,1,32'hA000_0009,32'h4);

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         drive(v.rst, v.stall, v.redir, v.rpc, v.gnt, v.rv, v.rdata);
         @(posedge clk_i); #1;
         chk("vec_req", i, {31'h0, imem_req_o}, {31'h0, v.e_req});
         if (v.e_req) chk("vec_addr", i, imem_addr_o, v.e_addr);
         chk("vec_valid", i, {31'h0, valid_if}, {31'h0, v.e_valid});
         if (v.chk_data) begin
            chk("vec_instr", i, instr_if32, v.e_instr);
            chk("vec_pc4",   i, pc_plus4_if32, v.e_pc4);
         end
      end

      // Randomized run against the reference model.
      mem_pend = 1'b0;
      mem_data = 32'h0;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      model_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk_i); #1;
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 149) == 0);
         rd  = ($urandom_range(0, 15) == 0);
         rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
                                           : {$urandom_range(0, 32'h3FFF), 2'b00};
         st  = ($urandom_range(0, 2) == 0);
         g   = !rst && m_req() && !mem_pend && ($urandom_range(0, 3) != 0);
         rv  = mem_pend && ($urandom_range(0, 1) == 0);
         rdat = rv ? mem_data : $urandom;
         if (rv) mem_pend = 1'b0;
         if (g) begin
            mem_pend = 1'b1;
            mem_data = $urandom;
         end
         drive(rst, st, rd, rpc, g, rv, rdat);
         model_step(rst, st, rd, rpc, g, rv, rdat);
         @(posedge clk_i); #1;
         chk("rnd_req", c, {31'h0, imem_req_o}, {31'h0, m_req()});
         if (m_req()) chk("rnd_addr", c, imem_addr_o, {m_pc[31:2], 2'b00});
         chk("rnd_valid", c, {31'h0, valid_if}, {31'h0, m_valid});
         if (m_valid) begin
            chk("rnd_instr", c, instr_if32, m_instr);
            chk("rnd_pc4",   c, pc_plus4_if32, m_pc4);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
